bitserial_poly_mac: RTL and testbench

//  Bit-serial schoolbook polynomial multiplier core. Consumes the 4-bit per-cycle coefficient-bit stream dcoef
//  (bit k of a0..a3, LSB first) from the circular-shift-register stage.

---
 rtl/bitserial_poly_mac.sv | 142 ++++++++++++++
 tb/tb_bitserial_poly_mac.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/bitserial_poly_mac.sv
// Bit-serial schoolbook multiplier: a(x) arrives one bit-plane per cycle on dcoef, b(x) is loaded in parallel.
// Optional NEGACYCLIC_EN folds the 7-term product modulo x^4+1 when results are registered.
module bitserial_poly_mac #(
    parameter int N     = 4,
    parameter int M     = 4,
    parameter int ACC_W = N + M + 2,
    parameter int OUT_W = ACC_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [M-1:0]     bdata0,
    input  logic [M-1:0]     bdata1,
    input  logic [M-1:0]     bdata2,
    input  logic [M-1:0]     bdata3,
    input  logic [3:0]       dcoef,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] c0,
    output logic [OUT_W-1:0] c1,
    output logic [OUT_W-1:0] c2,
    output logic [OUT_W-1:0] c3,
    output logic [OUT_W-1:0] c4,
    output logic [OUT_W-1:0] c5,
    output logic [OUT_W-1:0] c6
);
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    typedef logic [6:0][ACC_W-1:0] avec_t;
    typedef logic [6:0][OUT_W-1:0] cvec_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [3:0][M-1:0]      b_q, b_d;
    avec_t                  acc_q, acc_d;
    cvec_t                  c_q, c_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   accept;
    logic [3:0][M-1:0]      b_src;
    logic [CNT_W-1:0]       shamt;
    avec_t                  contrib;

    function automatic cvec_t fold(input avec_t a);
        cvec_t r;
        r = '0;
`ifdef NEGACYCLIC_EN
        // x^4 = -1: upper terms wrap around with negated sign
        r[0] = OUT_W'(a[0]) - OUT_W'(a[4]);
        r[1] = OUT_W'(a[1]) - OUT_W'(a[5]);
        r[2] = OUT_W'(a[2]) - OUT_W'(a[6]);
        r[3] = OUT_W'(a[3]);
`else
        for (int t = 0; t < 7; t++) r[t] = OUT_W'(a[t]);
`endif
        return r;
    endfunction

    // Per-cycle partial products; the start cycle uses the live b inputs at bit weight 0
    always_comb begin
        accept  = start && (state_q != RUN);
        b_src   = accept ? {bdata3, bdata2, bdata1, bdata0} : b_q;
        shamt   = accept ? '0 : cnt_q;
        contrib = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (dcoef[i])
                    contrib[i+j] = contrib[i+j] + (ACC_W'(b_src[j]) << shamt);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        b_d     = b_q;
        acc_d   = acc_q;
        c_d     = c_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (accept) begin
            b_d   = b_src;
            acc_d = contrib;
            cnt_d = CNT_W'(1);
            if (N == 1) begin
                state_d = FIN;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                c_d     = fold(contrib);
            end else begin
                state_d = RUN;
                busy_d  = 1'b1;
            end
        end else begin
            case (state_q)
                RUN: begin
                    for (int t = 0; t < 7; t++) acc_d[t] = acc_q[t] + contrib[t];
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(N - 1)) begin
                        state_d = FIN;
                        cnt_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        c_d     = fold(acc_d);
                    end
                end
                FIN:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            c_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            c_q     <= c_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign c0   = c_q[0];
    assign c1   = c_q[1];
    assign c2   = c_q[2];
    assign c3   = c_q[3];
    assign c4   = c_q[4];
    assign c5   = c_q[5];
    assign c6   = c_q[6];
endmodule

// File: tb/tb_bitserial_poly_mac.sv
// Bench for bitserial_poly_mac: spec vectors from a table, hand-built corner sequences, and random ops vs a product model.
module tb_bitserial_poly_mac;
    localparam int N = 4, M = 4, ACC_W = 10, OUT_W = 11;

    typedef logic [3:0][3:0]       q4_t;
    typedef logic [6:0][OUT_W-1:0] cvec_t;
    typedef struct {
        string name;
        q4_t   a;
        q4_t   b;
        cvec_t p;   // plain (non-reduced) product coefficients
    } vec_t;

    logic clk = 1'b0;
    logic reset, start;
    logic [3:0] bdata0, bdata1, bdata2, bdata3, dcoef;
    logic busy, done;
    logic [OUT_W-1:0] c0, c1, c2, c3, c4, c5, c6;
    cvec_t cout;

    int npass = 0;
    int ntot  = 0;

    bitserial_poly_mac #(.N(N), .M(M), .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
        .clk(clk), .reset(reset), .start(start),
        .bdata0(bdata0), .bdata1(bdata1), .bdata2(bdata2), .bdata3(bdata3),
        .dcoef(dcoef), .busy(busy), .done(done),
        .c0(c0), .c1(c1), .c2(c2), .c3(c3), .c4(c4), .c5(c5), .c6(c6)
    );

    always #5 clk = ~clk;
    assign cout = {c6, c5, c4, c3, c2, c1, c0};

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        ntot++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    endtask

    function automatic cvec_t fold(input cvec_t p);
        cvec_t r;
        r = '0;
`ifdef NEGACYCLIC_EN
        r[0] = p[0] - p[4];
        r[1] = p[1] - p[5];
        r[2] = p[2] - p[6];
        r[3] = p[3];
`else
        r = p;
`endif
        return r;
    endfunction

    function automatic cvec_t ref_mul(input q4_t a, input q4_t b);
        int s [7];
        cvec_t p;
        for (int t = 0; t < 7; t++) s[t] = 0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                s[i+j] += int'(a[i]) * int'(b[j]);
        for (int t = 0; t < 7; t++) p[t] = OUT_W'(s[t]);
        return fold(p);
    endfunction

    function automatic logic [3:0] bits(input q4_t a, input int k);
        return {a[3][k], a[2][k], a[1][k], a[0][k]};
    endfunction

    task automatic drive_start(input q4_t a, input q4_t b);
        start = 1'b1;
        {bdata3, bdata2, bdata1, bdata0} = b;
        dcoef = bits(a, 0);
    endtask

    task automatic drive_idle();
        start  = 1'b0;
        bdata0 = 4'($urandom); bdata1 = 4'($urandom);
        bdata2 = 4'($urandom); bdata3 = 4'($urandom);
        dcoef  = 4'($urandom);
    endtask

    task automatic check_c(input string tag, input cvec_t exp);
        for (int t = 0; t < 7; t++)
            chk($sformatf("%s c%0d", tag, t), 32'(cout[t]), 32'(exp[t]));
    endtask

    // Full operation from an idle cycle; checks busy window, done pulse, result and hold
    task automatic run_op(input string tag, input q4_t a, input q4_t b, input cvec_t exp);
        @(negedge clk);
        chk({tag, " busy_pre"}, 32'(busy), 32'd0);
        drive_start(a, b);
        for (int k = 1; k < N; k++) begin
            @(negedge clk);
            chk($sformatf("%s busy_k%0d", tag, k), 32'(busy), 32'd1);
            chk($sformatf("%s done_k%0d", tag, k), 32'(done), 32'd0);
            drive_idle();
            dcoef = bits(a, k);
        end
        @(negedge clk);
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " busy_fin"}, 32'(busy), 32'd0);
        check_c(tag, exp);
        drive_idle();
        @(negedge clk);
        chk({tag, " done_after"}, 32'(done), 32'd0);
        check_c({tag, " hold"}, exp);
    endtask

    vec_t vecs [3];
    q4_t  a1, b1, a2, b2, a3, b3, ra, rb;
    cvec_t e1, e3;

    initial begin
        vecs[0].name = "t1"; vecs[0].a = {4'd0, 4'd0, 4'd0, 4'd1};    vecs[0].b = {4'd9, 4'd7, 4'd5, 4'd3};
        vecs[0].p = {11'd0, 11'd0, 11'd0, 11'd9, 11'd7, 11'd5, 11'd3};
        vecs[1].name = "t2"; vecs[1].a = {4'd15, 4'd15, 4'd15, 4'd15}; vecs[1].b = {4'd15, 4'd15, 4'd15, 4'd15};
        vecs[1].p = {11'd225, 11'd450, 11'd675, 11'd900, 11'd675, 11'd450, 11'd225};
        vecs[2].name = "t3"; vecs[2].a = {4'd0, 4'd0, 4'd2, 4'd1};    vecs[2].b = {4'd0, 4'd0, 4'd1, 4'd1};
        vecs[2].p = {11'd0, 11'd0, 11'd0, 11'd0, 11'd2, 11'd3, 11'd1};
        a1 = vecs[0].a; b1 = vecs[0].b; e1 = fold(vecs[0].p);
        a2 = vecs[1].a; b2 = vecs[1].b;
        a3 = vecs[2].a; b3 = vecs[2].b; e3 = fold(vecs[2].p);

        reset = 1'b1;
        drive_idle();
        repeat (3) @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        check_c("reset", '0);
        reset = 1'b0;

        for (int v = 0; v < 3; v++)
            run_op(vecs[v].name, vecs[v].a, vecs[v].b, fold(vecs[v].p));
`ifdef NEGACYCLIC_EN
        run_op("t6", a2, b2, {11'd0, 11'd0, 11'd0, 11'd900, 11'd450, 11'd0, 11'h63E});
`endif

        // Abort: reset lands in the third bit cycle
        @(negedge clk); drive_start(a2, b2);
        @(negedge clk); drive_idle(); dcoef = bits(a2, 1);
        @(negedge clk); reset = 1'b1; dcoef = bits(a2, 2);
        @(negedge clk); reset = 1'b0; drive_idle();
        chk("abort busy", 32'(busy), 32'd0);
        check_c("abort", '0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("abort done%0d", k), 32'(done), 32'd0);
            @(negedge clk);
        end
        run_op("post_abort", a3, b3, e3);

        // Start while busy is ignored; start on the finishing cycle is accepted
        @(negedge clk); drive_start(a1, b1);
        @(negedge clk); drive_idle(); dcoef = bits(a1, 1);
        @(negedge clk); start = 1'b1; {bdata3, bdata2, bdata1, bdata0} = {4'd15, 4'd14, 4'd13, 4'd12};
        dcoef = bits(a1, 2);
        @(negedge clk); chk("restart busy", 32'(busy), 32'd1);
        drive_idle(); dcoef = bits(a1, 3);
        @(negedge clk);
        chk("b2b done1", 32'(done), 32'd1);
        check_c("b2b first", e1);
        drive_start(a3, b3);
        @(negedge clk);
        chk("b2b done_gap", 32'(done), 32'd0);
        chk("b2b busy", 32'(busy), 32'd1);
        check_c("b2b held", e1);
        drive_idle(); dcoef = bits(a3, 1);
        @(negedge clk); drive_idle(); dcoef = bits(a3, 2);
        @(negedge clk); drive_idle(); dcoef = bits(a3, 3);
        @(negedge clk);
        chk("b2b done2", 32'(done), 32'd1);
        check_c("b2b second", e3);
        drive_idle();

        for (int r = 0; r < 40; r++) begin
            ra = q4_t'($urandom);
            rb = q4_t'($urandom);
            if (r % 8 == 0) ra = '1;
            run_op($sformatf("rnd%0d", r), ra, rb, ref_mul(ra, rb));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
